// File: rtl/instr_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : instr_pkg
//  Description : Shared opcode, mnemonic-index and field-position constants
//                for the 8-bit Harvard core's instruction encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package instr_pkg;

   // Opcodes in bits [15:10]; these must match the core's control decoder
   localparam logic [5:0] c_op_mvi      = 6'b100000;
   localparam logic [5:0] c_op_mov      = 6'b100001;
   localparam logic [5:0] c_op_load     = 6'b100010;
   localparam logic [5:0] c_op_store    = 6'b100011;
   localparam logic [5:0] c_op_alu_base = 6'b010000;
   localparam logic [5:0] c_op_hlt      = 6'b111111;

   // Assembler mnemonic indices
   localparam logic [4:0] c_mn_mvi   = 5'd0;
   localparam logic [4:0] c_mn_mov   = 5'd1;
   localparam logic [4:0] c_mn_load  = 5'd2;
   localparam logic [4:0] c_mn_store = 5'd3;
   localparam logic [4:0] c_mn_add   = 5'd4;   // first ALU mnemonic
   localparam logic [4:0] c_mn_not   = 5'd11;  // unary ALU op, rt forced to 0
   localparam logic [4:0] c_mn_eq    = 5'd19;  // last ALU mnemonic
   localparam logic [4:0] c_mn_hlt   = 5'd20;

   // Field bit positions (LSB of each field)
   localparam int c_op_lsb  = 10;  // opcode, 6 bits
   localparam int c_f1_lsb  = 8;   // rd (or rs for store), 2 bits
   localparam int c_f2_lsb  = 6;   // rs, 2 bits
   localparam int c_f3_lsb  = 4;   // rt, 2 bits
   localparam int c_imm_lsb = 0;   // immediate / data address, 8 bits

   // Result of encoding one request
   typedef struct packed {
      logic        valid;
      logic        is_hlt;
      logic [15:0] word;
   } pack_t;

   // Encoder control states
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_STOP  = 2'd2
   } state_t;

endpackage
`default_nettype wire

// File: rtl/instr_encoder_if.sv
`default_nettype none
// ============================================================================
//  Module      : instr_encoder_if
//  Description : Request handshake plus instruction-memory write port for
//                the program-loading encoder.
//  Revision    : 1.0 - initial release
// ============================================================================
interface instr_encoder_if #(
   parameter int AW = 8,
   parameter int IW = 16
);
   logic          req_valid;
   logic          req_ready;
   logic [4:0]    req_mnem;
   logic [1:0]    req_rd;
   logic [1:0]    req_rs;
   logic [1:0]    req_rt;
   logic [7:0]    req_imm;
   logic          imem_we;
   logic [AW-1:0] imem_addr;
   logic [IW-1:0] imem_wdata;

   // Host / loader side
   modport master (
      output req_valid, req_mnem, req_rd, req_rs, req_rt, req_imm,
      input  req_ready, imem_we, imem_addr, imem_wdata
   );

   // Encoder side
   modport slave (
      input  req_valid, req_mnem, req_rd, req_rs, req_rt, req_imm,
      output req_ready, imem_we, imem_addr, imem_wdata
   );
endinterface
`default_nettype wire

// File: rtl/instr_field_pack.sv
`default_nettype none
// ============================================================================
//  Module      : instr_field_pack
//  Description : Combinational mnemonic/operand to 16-bit instruction word
//                packer; flags invalid mnemonics and hlt.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_field_pack
   import instr_pkg::*;
(
   input  wire [4:0] i_mnem,
   input  wire [1:0] i_rd,
   input  wire [1:0] i_rs,
   input  wire [1:0] i_rt,
   input  wire [7:0] i_imm,
   output pack_t     o_pack
);

   logic [4:0] w_alu_off;
   logic       w_is_alu;

   assign w_alu_off = i_mnem - c_mn_add;
   assign w_is_alu  = (i_mnem >= c_mn_add) && (i_mnem <= c_mn_eq);

   // Select opcode and place operand fields by instruction class
   always_comb begin
      o_pack = '0;
      case (i_mnem)
         c_mn_mvi, c_mn_load: begin
            o_pack.valid                  = 1'b1;
            o_pack.word[c_op_lsb +: 6]    = (i_mnem == c_mn_mvi) ? c_op_mvi : c_op_load;
            o_pack.word[c_f1_lsb +: 2]    = i_rd;
            o_pack.word[c_imm_lsb +: 8]   = i_imm;
         end
         c_mn_store: begin
            o_pack.valid                  = 1'b1;
            o_pack.word[c_op_lsb +: 6]    = c_op_store;
            o_pack.word[c_f1_lsb +: 2]    = i_rs;
            o_pack.word[c_imm_lsb +: 8]   = i_imm;
         end
         c_mn_mov: begin
            o_pack.valid                  = 1'b1;
            o_pack.word[c_op_lsb +: 6]    = c_op_mov;
            o_pack.word[c_f1_lsb +: 2]    = i_rd;
            o_pack.word[c_f2_lsb +: 2]    = i_rs;
         end
         c_mn_hlt: begin
            o_pack.valid                  = 1'b1;
            o_pack.is_hlt                 = 1'b1;
            o_pack.word[c_op_lsb +: 6]    = c_op_hlt;
         end
         default: begin
            if (w_is_alu) begin
               o_pack.valid               = 1'b1;
               o_pack.word[c_op_lsb +: 6] = c_op_alu_base + {1'b0, w_alu_off};
               o_pack.word[c_f1_lsb +: 2] = i_rd;
               o_pack.word[c_f2_lsb +: 2] = i_rs;
               o_pack.word[c_f3_lsb +: 2] = (i_mnem == c_mn_not) ? 2'b00 : i_rt;
            end
         end
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/instr_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : instr_encoder
//  Description : Accepts assembler-level requests, encodes them and writes
//                the words sequentially into instruction memory from 0.
//                Stops on hlt or a full memory; flags invalid mnemonics.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_encoder
   import instr_pkg::*;
#(
   parameter int AW = 8,
   parameter int IW = 16
)(
   input  wire             clk,
   input  wire             rst_n,
   input  wire             clear,
   instr_encoder_if.slave  bus,
   output logic [AW:0]     instr_count,
   output logic            done,
   output logic            full,
   output logic            err
);

   state_t        r_state;
   state_t        w_next;
   logic [AW-1:0] r_addr;
   logic [IW-1:0] r_word;
   logic          r_hlt;
   logic [AW:0]   r_count;
   logic          r_done;
   logic          r_full;
   logic          r_err;
   logic          r_ready;
   pack_t         w_pack;
   logic          w_accept;
   logic          w_last;

   instr_field_pack u_pack (
      .i_mnem (bus.req_mnem),
      .i_rd   (bus.req_rd),
      .i_rs   (bus.req_rs),
      .i_rt   (bus.req_rt),
      .i_imm  (bus.req_imm),
      .o_pack (w_pack)
   );

   // A request is taken only in IDLE, and never on a restart cycle
   assign w_accept = (r_state == ST_IDLE) && bus.req_valid && !clear;
   assign w_last   = (r_addr == {AW{1'b1}});

   // Next-state selection; clear overrides everything
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:  if (w_accept && w_pack.valid) w_next = ST_WRITE;
         ST_WRITE: w_next = (r_hlt || w_last) ? ST_STOP : ST_IDLE;
         ST_STOP:  w_next = ST_STOP;
         default:  w_next = ST_IDLE;
      endcase
      if (clear) w_next = ST_IDLE;
   end

   // State register; ready is registered so it stays low throughout reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_ready <= 1'b0;
      end else begin
         r_state <= w_next;
         r_ready <= (w_next == ST_IDLE);
      end
   end

   // Captured word, write address, count and sticky flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_word  <= '0;
         r_hlt   <= 1'b0;
         r_addr  <= '0;
         r_count <= '0;
         r_done  <= 1'b0;
         r_full  <= 1'b0;
         r_err   <= 1'b0;
      end else if (clear) begin
         r_addr  <= '0;
         r_count <= '0;
         r_done  <= 1'b0;
         r_full  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         if (w_accept) begin
            if (w_pack.valid) begin
               r_word <= w_pack.word;
               r_hlt  <= w_pack.is_hlt;
            end else begin
               r_err  <= 1'b1;
            end
         end
         if (r_state == ST_WRITE) begin
            r_addr  <= r_addr + AW'(1);
            r_count <= r_count + (AW+1)'(1);
            if (r_hlt)  r_done <= 1'b1;
            if (w_last) r_full <= 1'b1;
         end
      end
   end

   // Strobe decoded straight from state so an async reset drops it at once
   assign bus.imem_we    = (r_state == ST_WRITE);
   assign bus.imem_addr  = r_addr;
   assign bus.imem_wdata = r_word;
   assign bus.req_ready  = r_ready;
   assign instr_count    = r_count;
   assign done           = r_done;
   assign full           = r_full;
   assign err            = r_err;

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_encoder
//  Description : Self-checking bench for instr_encoder with a small
//                behavioural model of the encoding table and write sequence.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_encoder;

   localparam int AW    = 2;
   localparam int IW    = 16;
   localparam int DEPTH = 1 << AW;

   logic          clk   = 1'b0;
   logic          rst_n = 1'b0;
   logic          clear = 1'b0;
   logic [AW:0]   instr_count;
   logic          done;
   logic          full;
   logic          err;

   int n_vec  = 0;
   int n_miss = 0;

   // Model state
   int m_addr  = 0;
   int m_count = 0;
   bit m_done  = 0;
   bit m_full  = 0;
   bit m_err   = 0;
   bit m_stop  = 0;

   always #5 clk = ~clk;

   instr_encoder_if #(.AW(AW), .IW(IW)) bus ();

   instr_encoder #(.AW(AW), .IW(IW)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .clear       (clear),
      .bus         (bus),
      .instr_count (instr_count),
      .done        (done),
      .full        (full),
      .err         (err)
   );

   // Encoding from the mnemonic table: returns -1 for an invalid mnemonic
   function automatic int ref_word(input int mn, input int rd, input int rs,
                                   input int rt, input int imm);
      int op;
      if (mn == 0 || mn == 2) begin
         op = (mn == 0) ? 32 : 34;
         return op * 1024 + rd * 256 + imm;
      end else if (mn == 3) begin
         return 35 * 1024 + rs * 256 + imm;
      end else if (mn == 1) begin
         return 33 * 1024 + rd * 256 + rs * 64;
      end else if (mn >= 4 && mn <= 19) begin
         op = 16 + (mn - 4);
         return op * 1024 + rd * 256 + rs * 64 + ((mn == 11) ? 0 : rt) * 16;
      end else if (mn == 20) begin
         return 63 * 1024;
      end
      return -1;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_miss++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_addr = 0; m_count = 0;
      m_done = 0; m_full = 0; m_err = 0; m_stop = 0;
   endtask

   task automatic check_status(input string tag);
      check({tag, "_addr"},  32'(bus.imem_addr), 32'(m_addr));
      check({tag, "_count"}, 32'(instr_count),   32'(m_count));
      check({tag, "_done"},  32'(done),          32'(m_done));
      check({tag, "_full"},  32'(full),          32'(m_full));
      check({tag, "_err"},   32'(err),           32'(m_err));
      check({tag, "_ready"}, 32'(bus.req_ready), 32'(!m_stop));
      check({tag, "_we"},    32'(bus.imem_we),   32'(0));
   endtask

   // Issue one request starting at a negedge; ends at a negedge
   task automatic apply(input int mn, input int rd, input int rs, input int rt, input int imm);
      int w;
      int waited;
      bus.req_valid = 1'b1;
      bus.req_mnem  = 5'(mn);
      bus.req_rd    = 2'(rd);
      bus.req_rs    = 2'(rs);
      bus.req_rt    = 2'(rt);
      bus.req_imm   = 8'(imm);
      if (m_stop) begin
         repeat (3) begin
            check("stop_ready", 32'(bus.req_ready), 32'(0));
            check("stop_we",    32'(bus.imem_we),   32'(0));
            @(posedge clk); @(negedge clk);
         end
         bus.req_valid = 1'b0;
         check("stop_addr", 32'(bus.imem_addr), 32'(m_addr));
         return;
      end
      waited = 0;
      while (!bus.req_ready && waited < 10) begin
         @(negedge clk);
         waited++;
      end
      check("ready_wait", 32'(bus.req_ready), 32'(1));
      @(posedge clk); @(negedge clk);
      bus.req_valid = 1'b0;
      w = ref_word(mn, rd, rs, rt, imm);
      if (w < 0) begin
         m_err = 1;
         check_status("inv");
      end else begin
         check("wr_we",    32'(bus.imem_we),    32'(1));
         check("wr_addr",  32'(bus.imem_addr),  32'(m_addr));
         check("wr_data",  32'(bus.imem_wdata), 32'(w));
         check("wr_ready", 32'(bus.req_ready),  32'(0));
         @(posedge clk); @(negedge clk);
         if (mn == 20)            m_done = 1;
         if (m_addr == DEPTH - 1) m_full = 1;
         m_addr  = (m_addr + 1) % DEPTH;
         m_count = m_count + 1;
         m_stop  = m_done || m_full;
         check_status("post");
      end
   endtask

   task automatic pulse_clear();
      clear = 1'b1;
      @(posedge clk); @(negedge clk);
      clear = 1'b0;
      model_reset();
      check_status("clr");
   endtask

   initial begin
      int mn;
      bus.req_valid = 1'b0;
      bus.req_mnem  = '0;
      bus.req_rd    = '0;
      bus.req_rs    = '0;
      bus.req_rt    = '0;
      bus.req_imm   = '0;

      // Reset values while held in reset
      #2;
      check("rst_ready", 32'(bus.req_ready),  32'(0));
      check("rst_we",    32'(bus.imem_we),    32'(0));
      check("rst_wdata", 32'(bus.imem_wdata), 32'(0));
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); @(negedge clk);
      model_reset();
      check_status("rel");

      // Directed sequence
      apply(0, 2, 0, 0, 8'h5A);          // mvi -> 825A @0
      apply(4, 1, 2, 3, 0);              // add -> 41B0 @1
      apply(3, 0, 3, 0, 8'h10);          // store -> 8F10 @2
      apply(25, 1, 1, 1, 8'hFF);         // invalid, dropped
      pulse_clear();
      apply(11, 3, 1, 2, 0);             // not, rt forced 0
      apply(20, 0, 0, 0, 0);             // hlt -> done
      apply(0, 1, 0, 0, 8'h33);          // ignored while stopped
      pulse_clear();                     // addr back to 0
      apply(1, 2, 3, 0, 0);              // fill four words -> full
      apply(2, 1, 0, 0, 8'h80);
      apply(19, 3, 3, 3, 0);
      apply(18, 0, 1, 2, 0);
      apply(5, 0, 0, 0, 0);              // ignored while full
      pulse_clear();
      apply(0, 0, 0, 0, 1);
      apply(6, 1, 1, 1, 0);
      apply(7, 2, 2, 2, 0);
      apply(20, 0, 0, 0, 0);             // hlt on last address -> done and full
      pulse_clear();

      // Clear during WRITE: strobe still seen, then back to address 0
      apply(0, 1, 0, 0, 8'h11);
      bus.req_valid = 1'b1;
      bus.req_mnem  = 5'd4;
      @(posedge clk); @(negedge clk);
      bus.req_valid = 1'b0;
      clear = 1'b1;
      check("cw_we",   32'(bus.imem_we),   32'(1));
      check("cw_addr", 32'(bus.imem_addr), 32'(1));
      @(posedge clk); @(negedge clk);
      clear = 1'b0;
      model_reset();
      check_status("cw");

      // Randomized requests
      for (int i = 0; i < 80; i++) begin
         if (m_stop) begin
            pulse_clear();
         end else begin
            mn = (($urandom_range(0, 7) == 0) ? 20 : $urandom_range(0, 31));
            apply(mn, $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 3), $urandom_range(0, 255));
         end
      end
      if (m_stop) pulse_clear();

      // Reset asserted in the middle of a WRITE
      bus.req_valid = 1'b1;
      bus.req_mnem  = 5'd0;
      bus.req_imm   = 8'hC3;
      @(posedge clk);
      #2;
      check("mw_we_before", 32'(bus.imem_we), 32'(1));
      rst_n = 1'b0;
      #1;
      bus.req_valid = 1'b0;
      model_reset();
      check("mw_we",    32'(bus.imem_we),    32'(0));
      check("mw_ready", 32'(bus.req_ready),  32'(0));
      check("mw_addr",  32'(bus.imem_addr),  32'(0));
      check("mw_wdata", 32'(bus.imem_wdata), 32'(0));
      check("mw_count", 32'(instr_count),    32'(0));
      check("mw_done",  32'(done),           32'(0));
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); @(negedge clk);
      check_status("mw_rel");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
`default_nettype wire
